// File: rtl/ex_mem_pkg.sv
// Shared constants and types for the EX->MEM stage and its iterative multiplier.
package ex_mem_pkg;

  localparam int DATA_W_DEFAULT   = 64;
  localparam int MUL_BITS_DEFAULT = 4;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  localparam logic [1:0] MEMTOREG_ALU = 2'd0;
  localparam logic [1:0] MEMTOREG_MEM = 2'd1;
  localparam logic [1:0] MEMTOREG_PC4 = 2'd2;

  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: retires BITS_PER_CYC multiplier bits per BUSY cycle.
// start/abort/hold in, busy/done/product out; done marks the edge that finishes the product.
module ex_mul_iter
  import ex_mem_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int BITS_PER_CYC = MUL_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic [DATA_W-1:0] mcand_in,
  input  logic [DATA_W-1:0] mplier_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output logic              state_dbg
);

  localparam int MUL_CYCLES = DATA_W / BITS_PER_CYC;
  localparam int CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  mul_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] acc_next;

  always_comb begin
    partial = '0;
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      if (mplier[k]) partial = partial + (mcand << k);
    end
  end

  assign acc_next  = acc + partial;
  assign product   = acc_next;
  assign busy      = (state == MUL_BUSY) || start;
  assign done      = (state == MUL_BUSY) && (cnt == LAST_CNT) && !abort && !hold;
  assign state_dbg = (state == MUL_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (abort) begin
      state <= MUL_IDLE;
      cnt   <= '0;
    end else if (!hold) begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= mcand_in;
            mplier <= mplier_in;
            cnt    <= '0;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYC;
          mplier <= mplier >> BITS_PER_CYC;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register, NZCV flag register and MUL sequencing.
// Optional forwarding outputs fwd_valid/fwd_rd/fwd_data exist when EX_MEM_FWD_EN is defined.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W           = DATA_W_DEFAULT,
  parameter int MUL_BITS_PER_CYC = MUL_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_ex,
  input  logic              is_mul_ex,
  input  logic [DATA_W-1:0] data_a_ex,
  input  logic [DATA_W-1:0] data_b_ex,
  input  logic [DATA_W-1:0] alu_result_ex,
  input  logic [3:0]        alu_nzcv_ex,
  input  logic [31:0]       instr_ex,
  input  logic              MemWrite_ex,
  input  logic              read_en_ex,
  input  logic              RegWrite_ex,
  input  logic              flag_en_ex,
  input  logic [1:0]        MemToReg_ex,
  output logic              valid_mem,
  output logic [DATA_W-1:0] result_mem,
  output logic [DATA_W-1:0] store_data_mem,
  output logic [4:0]        rd_mem,
  output logic              MemWrite_mem,
  output logic              read_en_mem,
  output logic              RegWrite_mem,
  output logic [1:0]        MemToReg_mem,
  output logic [3:0]        nzcv,
  output logic              mul_busy_o,
`ifdef EX_MEM_FWD_EN
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              mul_state_dbg
);

  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic              retire_q;
  logic              unused_instr_bits;

  logic              valid_nxt;
  logic [DATA_W-1:0] result_nxt;
  logic [DATA_W-1:0] store_nxt;
  logic [4:0]        rd_nxt;
  logic              memwrite_nxt;
  logic              read_en_nxt;
  logic              regwrite_nxt;
  logic [1:0]        memtoreg_nxt;
  logic [3:0]        nzcv_nxt;
  logic              retire_nxt;

  assign unused_instr_bits = ^instr_ex[31:5];

  // The MUL stays in EX for one cycle after its product is written (the upstream
  // stall releases on that edge), so retire_q keeps it from being started again.
  assign mul_start = valid_ex && is_mul_ex && !retire_q;

  ex_mul_iter #(
    .DATA_W       (DATA_W),
    .BITS_PER_CYC (MUL_BITS_PER_CYC)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .abort     (flush_i),
    .hold      (stall_i),
    .mcand_in  (data_a_ex),
    .mplier_in (data_b_ex),
    .busy      (mul_busy_o),
    .done      (mul_done),
    .product   (mul_product),
    .state_dbg (mul_state_dbg)
  );

  always_comb begin
    valid_nxt    = 1'b0;
    result_nxt   = '0;
    store_nxt    = '0;
    rd_nxt       = '0;
    memwrite_nxt = 1'b0;
    read_en_nxt  = 1'b0;
    regwrite_nxt = 1'b0;
    memtoreg_nxt = MEMTOREG_ALU;
    nzcv_nxt     = nzcv;
    retire_nxt   = 1'b0;
    if (flush_i) begin
      retire_nxt = 1'b0;
    end else if (mul_done) begin
      valid_nxt    = 1'b1;
      result_nxt   = mul_product;
      store_nxt    = data_b_ex;
      rd_nxt       = instr_ex[4:0];
      memwrite_nxt = MemWrite_ex;
      read_en_nxt  = read_en_ex;
      regwrite_nxt = RegWrite_ex;
      memtoreg_nxt = MemToReg_ex;
      retire_nxt   = 1'b1;
    end else if (!(mul_busy_o || retire_q)) begin
      valid_nxt    = valid_ex;
      result_nxt   = alu_result_ex;
      store_nxt    = data_b_ex;
      rd_nxt       = instr_ex[4:0];
      memwrite_nxt = MemWrite_ex;
      read_en_nxt  = read_en_ex;
      regwrite_nxt = RegWrite_ex;
      memtoreg_nxt = MemToReg_ex;
      if (valid_ex && flag_en_ex) nzcv_nxt = alu_nzcv_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_mem      <= 1'b0;
      result_mem     <= '0;
      store_data_mem <= '0;
      rd_mem         <= '0;
      MemWrite_mem   <= 1'b0;
      read_en_mem    <= 1'b0;
      RegWrite_mem   <= 1'b0;
      MemToReg_mem   <= MEMTOREG_ALU;
      nzcv           <= 4'b0000;
      retire_q       <= 1'b0;
    end else if (flush_i || !stall_i) begin
      valid_mem      <= valid_nxt;
      result_mem     <= result_nxt;
      store_data_mem <= store_nxt;
      rd_mem         <= rd_nxt;
      MemWrite_mem   <= memwrite_nxt;
      read_en_mem    <= read_en_nxt;
      RegWrite_mem   <= regwrite_nxt;
      MemToReg_mem   <= memtoreg_nxt;
      nzcv           <= nzcv_nxt;
      retire_q       <= retire_nxt;
    end
  end

`ifdef EX_MEM_FWD_EN
  assign fwd_valid = valid_mem && RegWrite_mem && (rd_mem != XZR_IDX);
  assign fwd_rd    = rd_mem;
  assign fwd_data  = result_mem;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: behavioural model checked every cycle plus literal checks.
module tb_ex_mem_stage;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset, stall_i, flush_i, valid_ex, is_mul_ex;
  logic [W-1:0]  data_a_ex, data_b_ex, alu_result_ex;
  logic [3:0]    alu_nzcv_ex;
  logic [31:0]   instr_ex;
  logic          MemWrite_ex, read_en_ex, RegWrite_ex, flag_en_ex;
  logic [1:0]    MemToReg_ex;
  logic          valid_mem;
  logic [W-1:0]  result_mem, store_data_mem;
  logic [4:0]    rd_mem;
  logic          MemWrite_mem, read_en_mem, RegWrite_mem;
  logic [1:0]    MemToReg_mem;
  logic [3:0]    nzcv;
  logic          mul_busy_o, mul_state_dbg;
`ifdef EX_MEM_FWD_EN
  logic          fwd_valid;
  logic [4:0]    fwd_rd;
  logic [W-1:0]  fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  // model state
  logic          m_valid, m_memw, m_rden, m_regw;
  logic [W-1:0]  m_result, m_store, m_prod;
  logic [4:0]    m_rd;
  logic [1:0]    m_m2r;
  logic [3:0]    m_nzcv;
  logic          m_active, m_retire;
  int            m_left;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_ex(valid_ex), .is_mul_ex(is_mul_ex), .data_a_ex(data_a_ex),
    .data_b_ex(data_b_ex), .alu_result_ex(alu_result_ex), .alu_nzcv_ex(alu_nzcv_ex),
    .instr_ex(instr_ex), .MemWrite_ex(MemWrite_ex), .read_en_ex(read_en_ex),
    .RegWrite_ex(RegWrite_ex), .flag_en_ex(flag_en_ex), .MemToReg_ex(MemToReg_ex),
    .valid_mem(valid_mem), .result_mem(result_mem), .store_data_mem(store_data_mem),
    .rd_mem(rd_mem), .MemWrite_mem(MemWrite_mem), .read_en_mem(read_en_mem),
    .RegWrite_mem(RegWrite_mem), .MemToReg_mem(MemToReg_mem), .nzcv(nzcv),
    .mul_busy_o(mul_busy_o),
`ifdef EX_MEM_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .mul_state_dbg(mul_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_bubble();
    m_valid = 0; m_result = '0; m_store = '0; m_rd = '0;
    m_memw = 0; m_rden = 0; m_regw = 0; m_m2r = '0;
  endtask

  task automatic model_load(input logic v, input logic [W-1:0] res);
    m_valid = v; m_result = res; m_store = data_b_ex; m_rd = instr_ex[4:0];
    m_memw = MemWrite_ex; m_rden = read_en_ex; m_regw = RegWrite_ex; m_m2r = MemToReg_ex;
  endtask

  // A MUL is a fixed 16-edge occupancy after its start edge, then the product appears.
  always @(posedge clk) begin
    if (reset) begin
      model_bubble(); m_nzcv = 0; m_active = 0; m_retire = 0; m_left = 0; m_prod = '0;
    end else if (flush_i) begin
      model_bubble(); m_active = 0; m_retire = 0;
    end else if (!stall_i) begin
      if (m_active) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          model_load(1'b1, m_prod); m_active = 0; m_retire = 1;
        end else model_bubble();
      end else if (m_retire) begin
        model_bubble(); m_retire = 0;
      end else if (valid_ex && is_mul_ex) begin
        m_prod = data_a_ex * data_b_ex;
        m_active = 1; m_left = 16; model_bubble();
      end else begin
        model_load(valid_ex, alu_result_ex);
        if (valid_ex && flag_en_ex) m_nzcv = alu_nzcv_ex;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_mem", valid_mem, m_valid);
      check("result_mem", result_mem, m_result);
      check("store_data_mem", store_data_mem, m_store);
      check("rd_mem", rd_mem, m_rd);
      check("MemWrite_mem", MemWrite_mem, m_memw);
      check("read_en_mem", read_en_mem, m_rden);
      check("RegWrite_mem", RegWrite_mem, m_regw);
      check("MemToReg_mem", MemToReg_mem, m_m2r);
      check("nzcv", nzcv, m_nzcv);
      check("mul_busy_o", mul_busy_o, m_active || (!m_retire && valid_ex && is_mul_ex));
      check("mul_state_dbg", mul_state_dbg, m_active);
`ifdef EX_MEM_FWD_EN
      check("fwd_valid", fwd_valid, m_valid && m_regw && (m_rd != 5'd31));
      check("fwd_rd", fwd_rd, m_rd);
      check("fwd_data", fwd_data, m_result);
`endif
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    valid_ex = 0; is_mul_ex = 0; data_a_ex = '0; data_b_ex = '0; alu_result_ex = '0;
    alu_nzcv_ex = '0; instr_ex = '0; MemWrite_ex = 0; read_en_ex = 0; RegWrite_ex = 0;
    flag_en_ex = 0; MemToReg_ex = '0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [W-1:0] res, input logic [W-1:0] b,
                         input logic regw, input logic memw, input logic rden, input logic flag,
                         input logic [3:0] nz, input logic [1:0] m2r);
    set_idle();
    valid_ex = 1; alu_result_ex = res; data_b_ex = b; data_a_ex = 64'h0A0A;
    instr_ex = {27'h1234567, rd}; RegWrite_ex = regw; MemWrite_ex = memw;
    read_en_ex = rden; flag_en_ex = flag; alu_nzcv_ex = nz; MemToReg_ex = m2r;
  endtask

  task automatic set_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
    set_idle();
    valid_ex = 1; is_mul_ex = 1; data_a_ex = a; data_b_ex = b; alu_result_ex = 64'hBAD;
    instr_ex = {27'h0, rd}; RegWrite_ex = 1; alu_nzcv_ex = 4'hF;
  endtask

  // Holds the MUL in EX while mul_busy_o is high, as the upstream stages would.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd,
                         input int stall_at, input int stall_len, output int busy_cnt);
    logic done_seen;
    set_mul(a, b, rd);
    busy_cnt = 0;
    done_seen = 0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      stall_i = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
      #1;
      if (mul_busy_o) busy_cnt++;
      else if (busy_cnt > 0) done_seen = 1;
      if (!done_seen) step();
    end
    stall_i = 0;
    check("mul_completes", done_seen, 1'b1);
  endtask

  initial begin
    int bc;
    reset = 1; stall_i = 0; flush_i = 0;
    set_idle();
    step();
    chk_en = 1;
    step();
    check("reset_result", result_mem, 64'h0);
    check("reset_nzcv", nzcv, 4'h0);
    check("reset_busy", mul_busy_o, 1'b0);
    reset = 0;

    // ADD x3 = 5
    set_alu(5'd3, 64'h5, 64'h0, 1, 0, 0, 0, 4'h0, 2'd0);
    step();
    check("add_result", result_mem, 64'h5);
    check("add_rd", rd_mem, 5'd3);
    check("add_regwrite", RegWrite_mem, 1'b1);
    check("add_valid", valid_mem, 1'b1);

    // SUBS sets flags, following non-flag instruction leaves them
    set_alu(5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1, 0, 0, 1, 4'b0110, 2'd0);
    step();
    check("subs_nzcv", nzcv, 4'b0110);
    set_alu(5'd1, 64'h7, 64'h0, 1, 0, 0, 0, 4'b1111, 2'd0);
    step();
    check("noflag_nzcv", nzcv, 4'b0110);

    // store, load, invalid slot
    set_alu(5'd0, 64'h1000, 64'hDEAD_BEEF, 0, 1, 0, 0, 4'h0, 2'd0);
    step();
    check("store_data", store_data_mem, 64'hDEAD_BEEF);
    set_alu(5'd9, 64'h1008, 64'h0, 1, 0, 1, 0, 4'h0, 2'd1);
    step();
    set_idle();
    step();

    // MUL and back-to-back MUL
    run_mul(64'h1234, 64'h10, 5'd5, -1, 0, bc);
    check("mul_busy_cycles", bc, 17);
    check("mul_product", result_mem, 64'h12340);
    check("mul_valid", valid_mem, 1'b1);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, -1, 0, bc);
    check("mul2_busy_cycles", bc, 17);
    check("mul_neg_product", result_mem, 64'h1);
    set_idle();
    step();

    // MUL with a 5-cycle stall while BUSY
    run_mul(64'h1234, 64'h10, 5'd7, 3, 5, bc);
    check("mul_stall_busy_cycles", bc, 22);
    check("mul_stall_product", result_mem, 64'h12340);
    set_idle();
    step();
    step();

    // flush at cnt=7
    set_mul(64'hABC, 64'h3, 5'd8);
    repeat (8) step();
    flush_i = 1;
    set_idle();
    step();
    flush_i = 0;
    check("flush_valid", valid_mem, 1'b0);
    check("flush_busy", mul_busy_o, 1'b0);
    repeat (3) step();

    // flush wins over stall
    set_alu(5'd4, 64'h44, 64'h0, 1, 0, 0, 0, 4'h0, 2'd0);
    step();
    flush_i = 1; stall_i = 1;
    set_alu(5'd10, 64'h55, 64'h0, 1, 0, 0, 0, 4'h0, 2'd0);
    step();
    check("flush_stall_valid", valid_mem, 1'b0);
    check("flush_stall_result", result_mem, 64'h0);
    flush_i = 0; stall_i = 0;
    set_idle();
    step();

    // reset mid-multiply
    set_alu(5'd2, 64'h0, 64'h0, 0, 0, 0, 1, 4'b1001, 2'd0);
    step();
    set_mul(64'h5, 64'h6, 5'd11);
    repeat (5) step();
    reset = 1;
    set_idle();
    step();
    check("rst_mid_valid", valid_mem, 1'b0);
    check("rst_mid_result", result_mem, 64'h0);
    check("rst_mid_nzcv", nzcv, 4'h0);
    check("rst_mid_busy", mul_busy_o, 1'b0);
    reset = 0;
    set_alu(5'd7, 64'h77, 64'h0, 1, 0, 0, 0, 4'h0, 2'd0);
    step();
    check("post_rst_result", result_mem, 64'h77);
    check("post_rst_rd", rd_mem, 5'd7);

`ifdef EX_MEM_FWD_EN
    set_alu(5'd31, 64'h99, 64'h0, 1, 0, 0, 0, 4'h0, 2'd0);
    step();
    check("fwd_xzr", fwd_valid, 1'b0);
    set_alu(5'd4, 64'h66, 64'h0, 1, 0, 0, 0, 4'h0, 2'd0);
    step();
    check("fwd_valid_rd4", fwd_valid, 1'b1);
    check("fwd_data_rd4", fwd_data, 64'h66);
`endif

    set_idle();
    step();
    step();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
